// File: rtl/reg_swap_pkg.sv
// Shared types for the register swap bank: operation codes and FSM states.
package reg_swap_pkg;

    typedef enum logic [2:0] {
        OP_NOP    = 3'd0,
        OP_LOAD   = 3'd1,
        OP_SWAP   = 3'd2,
        OP_PRESET = 3'd3,
        OP_ROTL   = 3'd4,
        OP_ROTR   = 3'd5,
        OP_CLEAR  = 3'd6,
        OP_RSVD   = 3'd7
    } op_code_e;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ROTATE = 1'b1
    } state_e;

endpackage

// File: rtl/reg_word.sv
// One bank channel: WIDTH-bit register with enable and async active-high
// reset to RST_VAL. The next-value selection is done by the parent.
module reg_word #(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] word_q;

    // Hold unless enabled; reset returns the channel to its reset value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_q <= RST_VAL;
        end else if (en_i) begin
            word_q <= d_i;
        end
    end

    assign q_o = word_q;

endmodule

// File: rtl/reg_swap_bank.sv
// Bank of DEPTH registers with load / swap / preset / clear and a
// multi-cycle rotation, driven by a valid/ready operation port.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | ready for an op; single-cycle ops complete at the accept edge
// ST_ROTATE | one rotation step per edge until the step counter expires
module reg_swap_bank
    import reg_swap_pkg::*;
#(
    parameter int               WIDTH   = 4,
    parameter int               DEPTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    localparam int              IW      = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   op_valid,
    output logic                   op_ready,
    input  logic [2:0]             op_code,
    input  logic [IW-1:0]          idx_a,
    input  logic [IW-1:0]          idx_b,
    input  logic [WIDTH-1:0]       op_data,
    input  logic [IW-1:0]          rot_cnt,
    input  logic [IW-1:0]          rd_idx,
    output logic [WIDTH-1:0]       rd_data,
    output logic [DEPTH*WIDTH-1:0] bank_flat,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    logic [WIDTH-1:0] bank_q [DEPTH];
    logic [WIDTH-1:0] word_d [DEPTH];
    logic [DEPTH-1:0] word_en;

    state_e        state_q, state_d;
    logic [IW-1:0] cnt_q, cnt_d;
    logic          dir_q, dir_d;      // 1: ROTR, 0: ROTL
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          accept;
    op_code_e      op_sel;

    assign op_sel = op_code_e'(op_code);
    assign accept = op_valid && (state_q == ST_IDLE);

    // Next-value mux for every channel plus FSM / counter next state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        word_en = '0;
        for (int i = 0; i < DEPTH; i++) begin
            word_d[i] = bank_q[i];
        end

        if (state_q == ST_ROTATE) begin
            word_en = '1;
            for (int i = 0; i < DEPTH; i++) begin
                // IW-bit wrap gives the modulo-DEPTH neighbour for free.
                word_d[i] = dir_q ? bank_q[IW'(i + 1)] : bank_q[IW'(i - 1)];
            end
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == IW'(1)) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end
        end else if (accept) begin
            done_d = 1'b1;
            case (op_sel)
                OP_NOP: ;
                OP_LOAD: begin
                    word_en[idx_a] = 1'b1;
                    word_d[idx_a]  = op_data;
                end
                OP_SWAP: begin
                    word_en[idx_a] = 1'b1;
                    word_en[idx_b] = 1'b1;
                    word_d[idx_a]  = bank_q[idx_b];
                    word_d[idx_b]  = bank_q[idx_a];
                end
                OP_PRESET: begin
                    // a is written last so all-ones wins when a == b.
                    word_en[idx_b] = 1'b1;
                    word_d[idx_b]  = '0;
                    word_en[idx_a] = 1'b1;
                    word_d[idx_a]  = '1;
                end
                OP_ROTL, OP_ROTR: begin
                    // A zero count completes immediately as a no-op.
                    if (rot_cnt != '0) begin
                        state_d = ST_ROTATE;
                        cnt_d   = rot_cnt;
                        dir_d   = (op_sel == OP_ROTR);
                        done_d  = 1'b0;
                    end
                end
                OP_CLEAR: begin
                    word_en = '1;
                    for (int i = 0; i < DEPTH; i++) begin
                        word_d[i] = RST_VAL;
                    end
                end
                OP_RSVD: err_d = 1'b1;
                default: ;
            endcase
        end
    end

    // FSM, step counter and the registered completion/error pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_word
        reg_word #(
            .WIDTH   (WIDTH),
            .RST_VAL (RST_VAL)
        ) u_word (
            .clk   (clk),
            .reset (reset),
            .en_i  (word_en[g]),
            .d_i   (word_d[g]),
            .q_o   (bank_q[g])
        );
        assign bank_flat[g*WIDTH +: WIDTH] = bank_q[g];
    end

    assign op_ready = (state_q == ST_IDLE);
    assign busy     = (state_q == ST_ROTATE);
    assign done     = done_q;
    assign err      = err_q;
    assign rd_data  = bank_q[rd_idx];

endmodule

// File: tb/tb_reg_swap_bank.sv
// Bench for reg_swap_bank (WIDTH=4, DEPTH=4): directed ops, a closed-form
// behavioural model checked every cycle, and literal expectations.
module tb_reg_swap_bank;

    logic        clk;
    logic        reset;
    logic        op_valid;
    logic        op_ready;
    logic [2:0]  op_code;
    logic [1:0]  idx_a;
    logic [1:0]  idx_b;
    logic [3:0]  op_data;
    logic [1:0]  rot_cnt;
    logic [1:0]  rd_idx;
    logic [3:0]  rd_data;
    logic [15:0] bank_flat;
    logic        busy;
    logic        done;
    logic        err;

    int total = 0;
    int bad   = 0;

    reg_swap_bank #(.WIDTH(4), .DEPTH(4), .RST_VAL(4'h0)) dut (
        .clk       (clk),
        .reset     (reset),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .op_code   (op_code),
        .idx_a     (idx_a),
        .idx_b     (idx_b),
        .op_data   (op_data),
        .rot_cnt   (rot_cnt),
        .rd_idx    (rd_idx),
        .rd_data   (rd_data),
        .bank_flat (bank_flat),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Rotation is modelled in closed form: after s steps from snapshot,
    // ROTL gives snap[i-s], ROTR gives snap[i+s] (mod 4).
    int m_bank [4] = '{0, 0, 0, 0};
    int snap   [4] = '{0, 0, 0, 0};
    int m_left  = 0;
    int m_total = 0;
    bit m_dir   = 0;
    bit m_done  = 0;
    bit m_err   = 0;

    initial begin
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                for (int i = 0; i < 4; i++) m_bank[i] = 0;
                m_left = 0;
                m_done = 0;
                m_err  = 0;
            end else begin
                m_done = 0;
                m_err  = 0;
                if (m_left > 0) begin
                    int s;
                    m_left--;
                    s = m_total - m_left;
                    for (int i = 0; i < 4; i++)
                        m_bank[i] = m_dir ? snap[(i + s) % 4] : snap[(i - s + 4) % 4];
                    if (m_left == 0) m_done = 1;
                end else if (op_valid) begin
                    m_done = 1;
                    case (op_code)
                        3'd1: m_bank[idx_a] = int'(op_data);
                        3'd2: begin
                            int t;
                            t = m_bank[idx_a];
                            m_bank[idx_a] = m_bank[idx_b];
                            m_bank[idx_b] = t;
                        end
                        3'd3: begin
                            m_bank[idx_b] = 0;
                            m_bank[idx_a] = 15;
                        end
                        3'd4, 3'd5: begin
                            if (rot_cnt != 0) begin
                                snap    = m_bank;
                                m_total = int'(rot_cnt);
                                m_left  = int'(rot_cnt);
                                m_dir   = (op_code == 3'd5);
                                m_done  = 0;
                            end
                        end
                        3'd6: for (int i = 0; i < 4; i++) m_bank[i] = 0;
                        3'd7: m_err = 1;
                        default: ;
                    endcase
                end
            end
        end
    end

    // Every-cycle comparison of DUT against the model.
    initial begin
        forever begin
            logic [15:0] exp_flat;
            @(negedge clk);
            #1;
            for (int i = 0; i < 4; i++) exp_flat[i*4 +: 4] = m_bank[i][3:0];
            check("cyc_flat",  bank_flat, exp_flat);
            check("cyc_rd",    rd_data,   m_bank[rd_idx][3:0]);
            check("cyc_ready", op_ready,  (m_left == 0));
            check("cyc_busy",  busy,      (m_left > 0));
            check("cyc_done",  done,      m_done);
            check("cyc_err",   err,       m_err);
        end
    end

    // ---------------- stimulus ----------------
    task automatic op(input int code, input int a, input int b, input int d, input int k);
        op_valid = 1'b1;
        op_code  = 3'(code);
        idx_a    = 2'(a);
        idx_b    = 2'(b);
        op_data  = 4'(d);
        rot_cnt  = 2'(k);
        @(negedge clk);
        op_valid = 1'b0;
    endtask

    task automatic load_1234();
        for (int i = 0; i < 4; i++) op(1, i, 0, i + 1, 0);
    endtask

    initial begin
        #100000;
        bad++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        int busy_cnt;
        int done_seen;
        int rexp [4];

        reset    = 1'b1;
        op_valid = 1'b0;
        op_code  = '0;
        idx_a    = '0;
        idx_b    = '0;
        op_data  = '0;
        rot_cnt  = '0;
        rd_idx   = '0;
        #1;
        check("rst_flat",  bank_flat, 16'h0000);
        check("rst_ready", op_ready,  1'b1);
        check("rst_busy",  busy,      1'b0);
        check("rst_done",  done,      1'b0);
        #2 reset = 1'b0;
        @(negedge clk);

        // LOAD 1..4 back to back, then swaps
        load_1234();
        check("load_flat", bank_flat, 16'h4321);
        check("load_done", done, 1'b1);
        op(2, 1, 3, 0, 0);
        check("swap13_flat", bank_flat, 16'h2341);
        check("swap13_done", done, 1'b1);
        op(2, 2, 2, 0, 0);
        check("swap22_flat", bank_flat, 16'h2341);
        check("swap22_done", done, 1'b1);
        op(2, 3, 1, 0, 0);
        check("swap31_flat", bank_flat, 16'h4321);

        // PRESET and CLEAR
        op(3, 2, 0, 0, 0);
        check("preset20", bank_flat, 16'h4F20);
        op(3, 1, 1, 0, 0);
        check("preset11", bank_flat, 16'h4FF0);
        op(6, 0, 0, 0, 0);
        check("clear", bank_flat, 16'h0000);

        // ROTL k=3 with a LOAD held during busy
        load_1234();
        op(4, 0, 0, 0, 3);
        op_valid = 1'b1;
        op_code  = 3'd1;
        idx_a    = 2'd0;
        op_data  = 4'd9;
        busy_cnt = 0;
        while (!op_ready && busy_cnt < 10) begin
            busy_cnt++;
            @(negedge clk);
        end
        check("rotl_busy_cycles", busy_cnt, 3);
        check("rotl_flat", bank_flat, 16'h1432);
        check("rotl_done", done, 1'b1);
        @(negedge clk);
        op_valid = 1'b0;
        check("held_load_flat", bank_flat, 16'h1439);
        check("held_load_done", done, 1'b1);

        // ROTR k=1, rot_cnt=0, reserved code
        load_1234();
        op(5, 0, 0, 0, 1);
        check("rotr_busy", busy, 1'b1);
        @(negedge clk);
        check("rotr_flat", bank_flat, 16'h1432);
        check("rotr_done", done, 1'b1);
        op(4, 0, 0, 0, 0);
        check("rot0_busy", busy, 1'b0);
        check("rot0_done", done, 1'b1);
        check("rot0_flat", bank_flat, 16'h1432);
        op(7, 1, 2, 5, 0);
        check("rsvd_err",  err,  1'b1);
        check("rsvd_done", done, 1'b1);
        check("rsvd_flat", bank_flat, 16'h1432);

        // zero-latency read port
        rexp = '{2, 3, 4, 1};
        for (int i = 0; i < 4; i++) begin
            rd_idx = 2'(i);
            #1;
            check("rd_port", rd_data, 4'(rexp[i]));
        end
        @(negedge clk);

        // reset in the middle of a rotation
        op(4, 0, 0, 0, 3);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("abort_flat",  bank_flat, 16'h0000);
        check("abort_ready", op_ready,  1'b1);
        check("abort_busy",  busy,      1'b0);
        @(negedge clk);
        #2 reset = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        check("abort_no_done", done_seen, 0);
        op(1, 2, 0, 5, 0);
        check("post_abort_flat", bank_flat, 16'h0500);
        check("post_abort_done", done, 1'b1);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
